// File: rtl/prog_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader_pkg : shared widths, frame sync constant and loader FSM states  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package prog_loader_pkg;

  localparam int unsigned ADDR_WIDTH     = 16;
  localparam int unsigned DATA_WIDTH     = 8;
  localparam logic [7:0]  PROG_SYNC_BYTE = 8'hA5;

  // Each state names the byte the loader is waiting for next.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR_H = 4'd1,
    ST_ADDR_L = 4'd2,
    ST_LEN_H  = 4'd3,
    ST_LEN_L  = 4'd4,
    ST_DATA   = 4'd5,
    ST_CSUM   = 4'd6,
    ST_DONE   = 4'd7,
    ST_ERR    = 4'd8
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader_if : byte stream in, memory write port and CPU control out      |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface prog_loader_if #(
  parameter int unsigned ADDR_WIDTH = prog_loader_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = prog_loader_pkg::DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_err;

  // Environment side: byte source and memory / CPU sink.
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_addr, mem_wdata, mem_we, cpu_hold, load_done, load_err
  );

  // Loader side.
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_addr, mem_wdata, mem_we, cpu_hold, load_done, load_err
  );

endinterface
`default_nettype wire

// File: rtl/prog_loader_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader_timer : inter-byte down-counter, reload on load_i, expire at 0  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module prog_loader_timer #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic load_i,
  input  wire logic run_i,
  output logic      expire_o
);

  localparam int unsigned      CNT_W  = (CYCLES < 2) ? 1 : $clog2(CYCLES);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = RELOAD;
    end else if (run_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RELOAD;
    end else begin
      count_q <= count_d;
    end
  end

  // Reload counts as the first idle cycle, so expiry lands CYCLES edges after the last byte.
  assign expire_o = run_i && !load_i && (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | prog_loader : framed byte-stream loader into program memory, holds CPU in   |
// | reset until a frame checksum verifies. Option: PROG_LOADER_TIMEOUT_EN       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module prog_loader #(
  parameter int unsigned           ADDR_WIDTH     = prog_loader_pkg::ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH     = prog_loader_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE      = prog_loader_pkg::PROG_SYNC_BYTE,
  parameter int unsigned           TIMEOUT_CYCLES = 1_000_000
) (
  input  wire logic    clk,
  input  wire logic    reset,
  prog_loader_if.slave bus
);

  import prog_loader_pkg::*;

  localparam int unsigned LEN_W = 2 * DATA_WIDTH;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("prog_loader: TIMEOUT_CYCLES must be nonzero");
  end

  loader_state_t         state_q,     state_d;
  logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
  logic [LEN_W-1:0]      len_q,       len_d;
  logic [DATA_WIDTH-1:0] sum_q,       sum_d;
  logic                  mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  hold_q,      hold_d;
  logic                  done_q,      done_d;
  logic                  err_q,       err_d;

  logic                  w_fire;
  logic                  w_is_sync;
  logic [DATA_WIDTH-1:0] w_sum_next;
  logic [LEN_W-1:0]      w_len_full;
  logic                  w_timeout;

  assign w_fire     = bus.in_valid;
  assign w_is_sync  = (bus.in_data == SYNC_BYTE);
  assign w_sum_next = sum_q + bus.in_data;
  assign w_len_full = {len_q[LEN_W-1:DATA_WIDTH], bus.in_data};

`ifdef PROG_LOADER_TIMEOUT_EN
  logic w_timer_run;

  assign w_timer_run = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));

  prog_loader_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load_i   (w_fire),
    .run_i    (w_timer_run),
    .expire_o (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    sum_d       = sum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hold_d      = hold_q;
    done_d      = done_q;
    err_d       = err_q;

    if (w_fire) begin
      sum_d = w_sum_next;
      unique case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (w_is_sync) begin
            state_d = ST_ADDR_H;
            sum_d   = '0;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        ST_ADDR_H: begin
          addr_d  = ADDR_WIDTH'({bus.in_data, {DATA_WIDTH{1'b0}}});
          state_d = ST_ADDR_L;
        end
        ST_ADDR_L: begin
          addr_d  = addr_q | ADDR_WIDTH'(bus.in_data);
          state_d = ST_LEN_H;
        end
        ST_LEN_H: begin
          len_d   = {bus.in_data, {DATA_WIDTH{1'b0}}};
          state_d = ST_LEN_L;
        end
        ST_LEN_L: begin
          len_d   = w_len_full;
          state_d = (w_len_full == '0) ? ST_CSUM : ST_DATA;
        end
        ST_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = bus.in_data;
          addr_d      = addr_q + 1'b1;
          len_d       = len_q - 1'b1;
          if (len_q == LEN_W'(1)) begin
            state_d = ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (w_sum_next == '0) begin
            state_d = ST_DONE;
            hold_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      sum_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hold_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready  = 1'b1;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.load_done = done_q;
  assign bus.load_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_prog_loader : directed and random frames against a frame-level model     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_prog_loader;

`ifdef PROG_LOADER_TIMEOUT_EN
  localparam int unsigned TO = 50;
`else
  localparam int unsigned TO = 1_000_000;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

  prog_loader #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (8),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  logic [7:0]  frm[$];
  logic [7:0]  pl[$];
  bit          exp_ok;

  // Every strobe is one cycle wide, so one sample per falling edge sees it exactly once.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) got_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Builds the frame from the payload in pl; expected writes follow directly from base + index.
  task automatic make_frame(input logic [15:0] a, input logic [7:0] bad);
    int sum;
    frm.delete();
    exp_q.delete();
    frm.push_back(8'hA5);
    frm.push_back(a[15:8]);
    frm.push_back(a[7:0]);
    frm.push_back(8'(pl.size() >> 8));
    frm.push_back(8'(pl.size()));
    sum = 0;
    for (int i = 1; i < frm.size(); i++) sum += int'(frm[i]);
    foreach (pl[i]) begin
      frm.push_back(pl[i]);
      sum += int'(pl[i]);
      exp_q.push_back({16'(int'(a) + i), pl[i]});
    end
    frm.push_back(8'((256 - (sum % 256)) % 256) + bad);
    exp_ok = (bad == 8'h00);
  endtask

  task automatic send_bytes(input int from, input int to, input int gap);
    for (int i = from; i < to; i++) begin
      send(frm[i]);
      if (gap > 0) repeat ($urandom_range(0, gap)) @(negedge clk);
    end
  endtask

  task automatic finish_frame(input string tag);
    int n;
    repeat (2) @(negedge clk);
    check($sformatf("%s_nwrites", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_write%0d", tag, i), got_q[i], exp_q[i]);
    check($sformatf("%s_done", tag), bus.load_done, exp_ok);
    check($sformatf("%s_err", tag), bus.load_err, !exp_ok);
    check($sformatf("%s_hold", tag), bus.cpu_hold, !exp_ok);
    got_q.delete();
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  bad;
    logic [7:0]  nz;

    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.in_ready, 1);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_hold", bus.cpu_hold, 1);
    check("rst_done", bus.load_done, 0);
    check("rst_err", bus.load_err, 0);
    reset = 1'b0;
    @(negedge clk);

    // Good frame preceded by noise.
    send(8'h00);
    send(8'h13);
    pl = '{8'h10, 8'hFF, 8'h20};
    make_frame(16'hF000, 8'h00);
    check("t1_csum_byte", frm[frm.size()-1], 8'hDE);
    send_bytes(0, frm.size(), 0);
    finish_frame("t1");

    // Same frame, checksum off by one.
    make_frame(16'hF000, 8'h01);
    send_bytes(0, frm.size(), 0);
    finish_frame("t2");

    pl.delete();
    make_frame(16'hF000, 8'h00);
    send_bytes(0, frm.size(), 1);
    finish_frame("t3_len0");

    pl = '{8'hAA, 8'hBB};
    make_frame(16'hFFFF, 8'h00);
    send_bytes(0, frm.size(), 0);
    finish_frame("t4_wrap");

    // Reset lands on the same edge as the first payload byte: no write may appear.
    pl = '{8'h10, 8'hFF, 8'h20};
    make_frame(16'hF000, 8'h00);
    send_bytes(0, 5, 0);
    bus.in_data  = frm[5];
    bus.in_valid = 1'b1;
    reset        = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_nowrite", got_q.size(), 0);
    check("t5_hold", bus.cpu_hold, 1);
    check("t5_done", bus.load_done, 0);
    check("t5_err", bus.load_err, 0);
    got_q.delete();
    send_bytes(0, frm.size(), 0);
    finish_frame("t5_after");

`ifdef PROG_LOADER_TIMEOUT_EN
    make_frame(16'hF000, 8'h00);
    send_bytes(0, 5, 0);
    repeat (49) @(negedge clk);
    check("t6_err_early", bus.load_err, 0);
    repeat (2) @(negedge clk);
    check("t6_err_late", bus.load_err, 1);
    check("t6_hold", bus.cpu_hold, 1);
    check("t6_done", bus.load_done, 0);
    send_bytes(0, frm.size(), 0);
    finish_frame("t6_recover");
`endif

    for (int f = 0; f < 20; f++) begin
      pl.delete();
      repeat ($urandom_range(0, 10)) pl.push_back(8'($urandom_range(0, 255)));
      a = (f % 5 == 0) ? 16'(16'hFFFF - $urandom_range(0, 4)) : 16'($urandom_range(0, 65535));
      bad = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      make_frame(a, bad);
      repeat ($urandom_range(0, 2)) begin
        nz = 8'($urandom_range(0, 255));
        if (nz == 8'hA5) nz = 8'h00;
        send(nz);
      end
      send_bytes(0, frm.size(), 2);
      finish_frame($sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
